// File: rtl/axi_sram_slave.sv
// AXI4 memory slave (no IDs) backed by a flop-array SRAM.
// Independent read and write engines let one read burst and one write burst
// run concurrently. Supports FIXED, INCR and WRAP bursts of 32-bit beats.
module axi_sram_slave #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic        clk,
    input  logic        reset,
    // write address channel
    input  logic [31:0] s_awaddr,
    input  logic [7:0]  s_awlen,
    input  logic [2:0]  s_awsize,
    input  logic [1:0]  s_awburst,
    input  logic        s_awvalid,
    output logic        s_awready,
    // write data channel
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wlast,
    input  logic        s_wvalid,
    output logic        s_wready,
    // write response channel
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    // read address channel
    input  logic [31:0] s_araddr,
    input  logic [7:0]  s_arlen,
    input  logic [2:0]  s_arsize,
    input  logic [1:0]  s_arburst,
    input  logic        s_arvalid,
    output logic        s_arready,
    // read data channel
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rlast,
    output logic        s_rvalid,
    input  logic        s_rready
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Unsupported size, reserved burst type, or a WRAP length that is not 2/4/8/16 beats.
    function automatic logic burst_err(input logic [2:0] size,
                                       input logic [1:0] burst,
                                       input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size != 3'b010) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    // Word index of the following beat; INCR wraps naturally at the top of memory.
    function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx,
                                               input logic [1:0]    burst,
                                               input logic [7:0]    len);
        logic [AW-1:0] mask;
        logic [AW-1:0] res;
        mask = AW'(len);
        case (burst)
            2'b00:   res = idx;
            2'b10:   res = (idx & ~mask) | ((idx + AW'(1)) & mask);
            default: res = idx + AW'(1);
        endcase
        return res;
    endfunction

    logic [31:0] mem_q [MEM_WORDS];

    // Address bits outside the word index carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_awaddr[31:AW+2], s_awaddr[1:0],
                                s_araddr[31:AW+2], s_araddr[1:0]};

    // ---------------- write engine ----------------
    w_state_e      w_state_q, w_state_d;
    logic [AW-1:0] w_idx_q,   w_idx_d;
    logic [7:0]    w_len_q,   w_len_d;
    logic [1:0]    w_burst_q, w_burst_d;
    logic          w_err_q,   w_err_d;
    logic          w_over_q,  w_over_d;   // beat count ran past len without wlast
    logic [7:0]    w_cnt_q,   w_cnt_d;
    logic [1:0]    bresp_q,   bresp_d;
    logic          w_we;

    assign s_awready = (w_state_q == W_IDLE);
    assign s_wready  = (w_state_q == W_DATA);
    assign s_bvalid  = (w_state_q == W_RESP);
    assign s_bresp   = bresp_q;

    assign w_we = (w_state_q == W_DATA) && s_wvalid && !w_err_q && !w_over_q;

    // Write FSM next-state and burst bookkeeping.
    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        w_over_d  = w_over_q;
        w_cnt_d   = w_cnt_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (s_awvalid) begin
                    w_idx_d   = s_awaddr[AW+1:2];
                    w_len_d   = s_awlen;
                    w_burst_d = s_awburst;
                    w_err_d   = burst_err(s_awsize, s_awburst, s_awlen);
                    w_over_d  = 1'b0;
                    w_cnt_d   = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_wvalid) begin
                    w_idx_d = next_idx(w_idx_q, w_burst_q, w_len_q);
                    if (!w_over_q && (w_cnt_q != w_len_q)) begin
                        w_cnt_d = w_cnt_q + 8'd1;
                    end
                    if (!w_over_q && (w_cnt_q == w_len_q) && !s_wlast) begin
                        w_over_d = 1'b1;
                    end
                    if (s_wlast) begin
                        bresp_d   = (w_err_q || w_over_q || (w_cnt_q != w_len_q))
                                    ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write engine state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
            w_over_q  <= 1'b0;
            w_cnt_q   <= '0;
            bresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
            w_over_q  <= w_over_d;
            w_cnt_q   <= w_cnt_d;
            bresp_q   <= bresp_d;
        end
    end

    // Byte-lane writes into the memory array (contents are not reset).
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_we && s_wstrb[i]) begin
                mem_q[w_idx_q][8*i +: 8] <= s_wdata[8*i +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_e      r_state_q, r_state_d;
    logic [AW-1:0] r_idx_q,   r_idx_d;
    logic [7:0]    r_len_q,   r_len_d;
    logic [1:0]    r_burst_q, r_burst_d;
    logic          r_err_q,   r_err_d;
    logic [7:0]    r_cnt_q,   r_cnt_d;
    logic [31:0]   rdata_q,   rdata_d;
    logic          ar_err;
    logic [AW-1:0] ar_idx;
    logic [AW-1:0] r_nidx;

    assign ar_err = burst_err(s_arsize, s_arburst, s_arlen);
    assign ar_idx = s_araddr[AW+1:2];
    assign r_nidx = next_idx(r_idx_q, r_burst_q, r_len_q);

    assign s_arready = (r_state_q == R_IDLE);
    assign s_rvalid  = (r_state_q == R_DATA);
    assign s_rlast   = s_rvalid && (r_cnt_q == r_len_q);
    assign s_rresp   = (s_rvalid && r_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_rdata   = rdata_q;

    // Read FSM; rdata_q is loaded on the edge that accepts AR or a non-last beat,
    // so a write committing on that same edge is seen only by later loads.
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_err_d   = r_err_q;
        r_cnt_d   = r_cnt_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_arvalid) begin
                    r_idx_d   = ar_idx;
                    r_len_d   = s_arlen;
                    r_burst_d = s_arburst;
                    r_err_d   = ar_err;
                    r_cnt_d   = '0;
                    rdata_d   = ar_err ? '0 : mem_q[ar_idx];
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_rready) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d = r_nidx;
                        r_cnt_d = r_cnt_q + 8'd1;
                        rdata_d = r_err_q ? '0 : mem_q[r_nidx];
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read engine state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_burst_q <= '0;
            r_err_q   <= 1'b0;
            r_cnt_q   <= '0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_err_q   <= r_err_d;
            r_cnt_q   <= r_cnt_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave.
module tb_axi_sram_slave;

    logic        clk;
    logic        reset;
    logic [31:0] s_awaddr;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready;

    int total = 0;
    int bad   = 0;

    logic [31:0] wd [16];
    logic [31:0] re [16];

    axi_sram_slave #(.MEM_WORDS(1024)) dut (
        .clk(clk), .reset(reset),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
        .s_rready(s_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int nb, input logic [3:0] strb,
                            input logic [1:0] exp_resp, input int bstall);
        int n;
        @(negedge clk);
        s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst; s_awvalid = 1'b1;
        n = 0;
        while (!s_awready && n < 20) begin @(negedge clk); n++; end
        chk("aw_ready", {31'd0, s_awready}, 32'd1);
        @(negedge clk);
        s_awvalid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            s_wdata = wd[b]; s_wstrb = strb; s_wlast = (b == nb - 1); s_wvalid = 1'b1;
            n = 0;
            while (!s_wready && n < 20) begin @(negedge clk); n++; end
            chk("w_ready", {31'd0, s_wready}, 32'd1);
            @(negedge clk);
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        chk("bvalid", {31'd0, s_bvalid}, 32'd1);
        chk("bresp", {30'd0, s_bresp}, {30'd0, exp_resp});
        chk("wready_off", {31'd0, s_wready}, 32'd0);
        repeat (bstall) begin
            @(negedge clk);
            chk("bvalid_hold", {31'd0, s_bvalid}, 32'd1);
            chk("bresp_hold", {30'd0, s_bresp}, {30'd0, exp_resp});
        end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        chk("bvalid_done", {31'd0, s_bvalid}, 32'd0);
        chk("awready_back", {31'd0, s_awready}, 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int nb, input logic [1:0] exp_resp, input int stall_at);
        int n;
        @(negedge clk);
        s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst; s_arvalid = 1'b1;
        n = 0;
        while (!s_arready && n < 20) begin @(negedge clk); n++; end
        chk("ar_ready", {31'd0, s_arready}, 32'd1);
        @(negedge clk);
        s_arvalid = 1'b0;
        chk("ar_busy", {31'd0, s_arready}, 32'd0);
        for (int b = 0; b < nb; b++) begin
            chk("rvalid", {31'd0, s_rvalid}, 32'd1);
            chk("rdata", s_rdata, re[b]);
            chk("rresp", {30'd0, s_rresp}, {30'd0, exp_resp});
            chk("rlast", {31'd0, s_rlast}, {31'd0, (b == nb - 1)});
            if (b == stall_at) begin
                repeat (3) begin
                    @(negedge clk);
                    chk("rvalid_hold", {31'd0, s_rvalid}, 32'd1);
                    chk("rdata_hold", s_rdata, re[b]);
                    chk("rresp_hold", {30'd0, s_rresp}, {30'd0, exp_resp});
                    chk("rlast_hold", {31'd0, s_rlast}, {31'd0, (b == nb - 1)});
                end
            end
            s_rready = 1'b1;
            @(negedge clk);
            s_rready = 1'b0;
        end
        chk("rvalid_done", {31'd0, s_rvalid}, 32'd0);
        chk("arready_back", {31'd0, s_arready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = 1'b0;
        s_rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awready", {31'd0, s_awready}, 32'd1);
        chk("rst_arready", {31'd0, s_arready}, 32'd1);
        chk("rst_wready", {31'd0, s_wready}, 32'd0);
        chk("rst_bvalid", {31'd0, s_bvalid}, 32'd0);
        chk("rst_rvalid", {31'd0, s_rvalid}, 32'd0);
        chk("rst_rlast", {31'd0, s_rlast}, 32'd0);
        chk("rst_bresp", {30'd0, s_bresp}, 32'd0);
        chk("rst_rresp", {30'd0, s_rresp}, 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        reset = 1'b1;

        // INCR write then readback; B held for 2 cycles.
        wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
        do_write(32'h100, 8'd3, 3'b010, 2'b01, 4, 4'hF, 2'b00, 2);
        re[0] = 32'hA0; re[1] = 32'hA1; re[2] = 32'hA2; re[3] = 32'hA3;
        do_read(32'h100, 8'd3, 3'b010, 2'b01, 4, 2'b00, -1);

        // WRAP read starting mid-block: words 0x40..0x43 = 1..4.
        wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
        do_write(32'h100, 8'd3, 3'b010, 2'b01, 4, 4'hF, 2'b00, 0);
        re[0] = 32'd3; re[1] = 32'd4; re[2] = 32'd1; re[3] = 32'd2;
        do_read(32'h108, 8'd3, 3'b010, 2'b10, 4, 2'b00, -1);
        // WRAP with illegal len=2: three beats of zero, SLVERR.
        re[0] = 32'd0; re[1] = 32'd0; re[2] = 32'd0;
        do_read(32'h108, 8'd2, 3'b010, 2'b10, 3, 2'b10, -1);

        // Read backpressure: 3-cycle stall on beat 1.
        re[0] = 32'd1; re[1] = 32'd2; re[2] = 32'd3; re[3] = 32'd4;
        do_read(32'h100, 8'd3, 3'b010, 2'b01, 4, 2'b00, 1);

        // Partial strobe merge.
        wd[0] = 32'h1234_5678;
        do_write(32'h200, 8'd0, 3'b010, 2'b01, 1, 4'hF, 2'b00, 0);
        wd[0] = 32'hFFFF_FFFF;
        do_write(32'h200, 8'd0, 3'b010, 2'b01, 1, 4'b0101, 2'b00, 0);
        re[0] = 32'h12FF_56FF;
        do_read(32'h200, 8'd0, 3'b010, 2'b01, 1, 2'b00, -1);

        // Bad awsize: memory unchanged, SLVERR.
        wd[0] = 32'hDEAD_BEEF; wd[1] = 32'hCAFE_F00D;
        do_write(32'h300, 8'd1, 3'b010, 2'b01, 2, 4'hF, 2'b00, 0);
        wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222;
        do_write(32'h300, 8'd1, 3'b001, 2'b01, 2, 4'hF, 2'b10, 0);
        re[0] = 32'hDEAD_BEEF; re[1] = 32'hCAFE_F00D;
        do_read(32'h300, 8'd1, 3'b010, 2'b01, 2, 2'b00, -1);

        // Early wlast on beat 1 of len=3: beats 0,1 written, SLVERR.
        wd[0] = 32'd0; wd[1] = 32'd0; wd[2] = 32'd0; wd[3] = 32'd0;
        do_write(32'h400, 8'd3, 3'b010, 2'b01, 4, 4'hF, 2'b00, 0);
        wd[0] = 32'h55; wd[1] = 32'h66;
        do_write(32'h400, 8'd3, 3'b010, 2'b01, 2, 4'hF, 2'b10, 0);
        re[0] = 32'h55; re[1] = 32'h66; re[2] = 32'd0; re[3] = 32'd0;
        do_read(32'h400, 8'd3, 3'b010, 2'b01, 4, 2'b00, -1);

        // Late wlast: extra beat after len accepted but not written, SLVERR.
        wd[0] = 32'h77; wd[1] = 32'h88; wd[2] = 32'h99;
        do_write(32'h400, 8'd1, 3'b010, 2'b01, 3, 4'hF, 2'b10, 0);
        re[0] = 32'h77; re[1] = 32'h88; re[2] = 32'd0;
        do_read(32'h400, 8'd2, 3'b010, 2'b01, 3, 2'b00, -1);

        // FIXED write keeps hitting one word; FIXED read repeats it.
        wd[0] = 32'd7; wd[1] = 32'd8; wd[2] = 32'd9;
        do_write(32'h500, 8'd2, 3'b010, 2'b00, 3, 4'hF, 2'b00, 0);
        re[0] = 32'd9; re[1] = 32'd9;
        do_read(32'h500, 8'd1, 3'b010, 2'b00, 2, 2'b00, -1);

        // INCR wraps from the top word back to word 0.
        wd[0] = 32'hAAAA_0001; wd[1] = 32'hBBBB_0002;
        do_write(32'hFFC, 8'd1, 3'b010, 2'b01, 2, 4'hF, 2'b00, 0);
        re[0] = 32'hBBBB_0002;
        do_read(32'h000, 8'd0, 3'b010, 2'b01, 1, 2'b00, -1);

        // Reset in the middle of a read burst.
        @(negedge clk);
        s_araddr = 32'h100; s_arlen = 8'd3; s_arsize = 3'b010; s_arburst = 2'b01;
        s_arvalid = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0;
        chk("mid_rdata0", s_rdata, 32'd1);
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        chk("mid_rvalid1", {31'd0, s_rvalid}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_rvalid", {31'd0, s_rvalid}, 32'd0);
        chk("rst_mid_rdata", s_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        chk("rst_mid_arready", {31'd0, s_arready}, 32'd1);
        re[0] = 32'd1; re[1] = 32'd2; re[2] = 32'd3; re[3] = 32'd4;
        do_read(32'h100, 8'd3, 3'b010, 2'b01, 4, 2'b00, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 memory slave (no IDs) attached to one slave port of the AXI crossbar.
- Its channel widths match the crossbar slave side: 32-bit address and data, 8-bit len, 3-bit size, 2-bit burst, 4-bit strobe.
- Backs a flop-array SRAM with independent read and write engines, so one read burst and one write burst can proceed concurrently.
- Supports FIXED, INCR and WRAP bursts of 32-bit beats.

Parameters:
- MEM_WORDS, 1024, memory depth in 32-bit words; power of two, minimum 16.
- AW, $clog2(MEM_WORDS), word-index width; derived, not to be overridden.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- s_awaddr/s_awlen/s_awsize/s_awburst  in  32/8/3/2  write address channel
- s_awvalid  in  1; s_awready  out  1
- s_wdata/s_wstrb/s_wlast/s_wvalid  in  32/4/1/1; s_wready  out  1
- s_bresp  out  2; s_bvalid  out  1; s_bready  in  1
- s_araddr/s_arlen/s_arsize/s_arburst  in  32/8/3/2  read address channel
- s_arvalid  in  1; s_arready  out  1
- s_rdata  out  32; s_rresp  out  2; s_rlast  out  1; s_rvalid  out  1; s_rready  in  1

Behaviour:
- Reset (reset=0, async) puts both FSMs in IDLE and drives the outputs to these values:
  - s_awready=1, s_arready=1
  - s_wready=0, s_bvalid=0, s_rvalid=0, s_rlast=0
  - s_bresp=0, s_rresp=0, s_rdata=0
- Memory contents are not reset. Reset mid-burst abandons the burst; no partial response is issued.
- Word index is addr[AW+1:2]. addr[1:0] and bits above AW+1 are ignored; the crossbar has already decoded the slave.
- A burst is an error burst if any of the following hold:
  - size != 3'b010
  - burst == 2'b11
  - WRAP with len not in {1,3,7,15}
- Index advance per beat:
  - FIXED: unchanged.
  - INCR: idx+1, modulo MEM_WORDS (wraps at the top of memory).
  - WRAP: (idx & ~len[AW-1:0]) | ((idx+1) & len[AW-1:0]).
- Write FSM has three states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On the AW handshake, latch idx/len/burst/error flag, set beat counter to 0, go to W_DATA with awready=0 and wready=1 from the next cycle.
  - W_DATA: on each W handshake, for each byte lane i with strb[i]=1, write mem[idx][8i+7:8i] (skipped if error burst). Then advance idx and the counter.
  - W_DATA exit: on the handshake with wlast=1, go to W_RESP; wready=0 and bvalid=1 from the next cycle.
  - bresp = 2'b10 if error burst, or if wlast arrives on a beat != len (early or late). Otherwise 2'b00.
  - Beats after the counter reaches len without wlast are accepted but not written.
  - W_RESP: hold bvalid and bresp until bready. On the handshake go to W_IDLE; awready=1 the next cycle.
- Read FSM has two states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On the AR handshake in cycle N, load rdata_q from mem[idx] (0 if error burst) and go to R_DATA.
  - From cycle N+1: rvalid=1, rresp = 2'b10 if error burst else 2'b00, rlast = (beat == len).
  - s_rdata, s_rresp and s_rlast hold stable while rvalid=1 and rready=0.
  - R handshake when not last: advance idx and reload rdata_q from the new index in the same edge. Next beat valid the following cycle, so throughput is one beat per clock.
  - R handshake on the last beat: rvalid=0, go to R_IDLE, arready=1 the next cycle.
- Read/write collision: when a write commits in the same cycle rdata_q is loaded from the same word, the read returns the old data. The written value is visible to any later load.
- Read and write engines are fully independent; AW and AR handshakes in the same cycle are both accepted.
- Minimum latencies:
  - AR handshake to first rvalid: 1 cycle.
  - wlast handshake to bvalid: 1 cycle.
  - B handshake to next awready: 1 cycle.

Test Plan:
- Reset, then INCR write: awaddr=0x100, len=3, strb=4'hF, data 0xA0..0xA3 → bresp=00 one cycle after wlast. Then INCR read of the same burst → rdata 0xA0,0xA1,0xA2,0xA3; rlast only on the 4th beat; rresp=00.
- WRAP read: araddr=0x108, len=3, memory words 0x40..0x43 = 1,2,3,4 → beats 3,4,1,2. Same read with len=2 → four beats? No: three beats of 0 with rresp=10.
- Partial strobe write: strb=4'b0101, data 0xFFFF_FFFF to a word holding 0x1234_5678 → readback 0x12FF_56FF.
- Backpressure: rready low for 3 cycles mid-burst → rdata/rlast/rresp stable. bready low for 2 cycles → bvalid and bresp held.
- Error cases:
  - awsize=3'b001 with 2 beats → no memory change, bresp=10.
  - wlast asserted on beat 1 of a len=3 burst → bresp=10, and beat 0 plus beat 1 are written.
- Reset asserted mid read burst → rvalid=0 immediately. After release, arready=1 and a new burst completes normally.
